// File: rtl/alu_fault_pkg.sv
// alu_fault_pkg
//   Shared definitions for the ALU lockstep fault monitor: the fault
//   classification FSM encoding, the Wishbone register offsets, the bit
//   positions inside CTRL / STATUS, and the layout of the FIRST snapshot.
package alu_fault_pkg;

  // Fault classification states. The encoding is visible in STATUS[3:2].
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MONITOR   = 2'd1,
    ST_TRANSIENT = 2'd2,
    ST_LOCKED    = 2'd3
  } fsm_state_e;

  // Register byte offsets within the 256-byte window.
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_SAMPLE = 8'h08;
  localparam logic [7:0] OFF_FAULT  = 8'h0C;
  localparam logic [7:0] OFF_FIRST  = 8'h10;
  localparam logic [7:0] OFF_THRESH = 8'h14;

  // CTRL bits.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  // STATUS bits.
  localparam int STATUS_STICKY    = 0;
  localparam int STATUS_LOCKED    = 1;
  localparam int STATUS_STATE_LSB = 2;
  localparam int STATUS_CONS_LSB  = 4;

  // FIRST snapshot field positions.
  localparam int FIRST_X_LSB   = 0;
  localparam int FIRST_Y       = 4;
  localparam int FIRST_A1_LSB  = 8;
  localparam int FIRST_A2_LSB  = 12;
  localparam int FIRST_IDX_LSB = 16;

  // Assemble the FIRST snapshot word; bits [7:5] are reserved and read 0.
  function automatic logic [31:0] pack_first(input logic [3:0]  x,
                                             input logic        y,
                                             input logic [3:0]  a1,
                                             input logic [3:0]  a2,
                                             input logic [15:0] idx);
    logic [31:0] w;
    w = '0;
    w[FIRST_X_LSB +: 4]    = x;
    w[FIRST_Y]             = y;
    w[FIRST_A1_LSB +: 4]   = a1;
    w[FIRST_A2_LSB +: 4]   = a2;
    w[FIRST_IDX_LSB +: 16] = idx;
    return w;
  endfunction

endpackage

// File: rtl/alu_fault_wb_regs.sv
// alu_fault_wb_regs
//   Wishbone slave front-end of the fault monitor: address decode, one-cycle
//   acknowledge, CTRL / THRESH storage and the registered read mux.
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   wbs_*                Wishbone slave bus (classic, single-cycle ack)
//   sticky_i .. first_i  live status from the monitor core, for readback
//   en_o, irq_en_o       CTRL enable bits
//   thresh_o             persistent-fault threshold (never 0)
//   clr_o                one-cycle clear pulse, same cycle as the CTRL write
//   clr_en_o             value of en taking effect with that clear
module alu_fault_wb_regs
  import alu_fault_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [3:0]  PERSIST_TH = 4'd3
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        sticky_i,
  input  fsm_state_e  state_i,
  input  logic [3:0]  cons_i,
  input  logic [31:0] sample_cnt_i,
  input  logic [15:0] fault_cnt_i,
  input  logic [31:0] first_i,
  output logic        en_o,
  output logic        irq_en_o,
  output logic [3:0]  thresh_o,
  output logic        clr_o,
  output logic        clr_en_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic [3:0]  thresh_q, thresh_d;

  logic        base_hit, access, wr, rd;
  logic [7:0]  offset;
  logic [31:0] rdata;

  // Only the low byte of writable registers carries state.
  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:4], wbs_sel_i[3:1]};

  always_comb begin
    base_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // The !ack term stops a held strobe from being seen as a second access.
    access   = wbs_stb_i & wbs_cyc_i & base_hit & ~ack_q;
    wr       = access & wbs_we_i;
    rd       = access & ~wbs_we_i;
    offset   = wbs_adr_i[7:0];

    en_d     = en_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    clr_o    = 1'b0;

    if (wr && wbs_sel_i[0]) begin
      case (offset)
        OFF_CTRL: begin
          en_d     = wbs_dat_i[CTRL_EN];
          irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
          clr_o    = wbs_dat_i[CTRL_CLR];
        end
        OFF_THRESH: begin
          // A threshold of 0 would never be reached; treat it as 1.
          thresh_d = (wbs_dat_i[3:0] == 4'd0) ? 4'd1 : wbs_dat_i[3:0];
        end
        default: ;
      endcase
    end
    clr_en_o = en_d;

    rdata = '0;
    case (offset)
      OFF_CTRL:   rdata = {30'd0, irq_en_q, en_q};
      OFF_STATUS: rdata = {24'd0, cons_i, state_i, (state_i == ST_LOCKED), sticky_i};
      OFF_SAMPLE: rdata = sample_cnt_i;
      OFF_FAULT:  rdata = {16'd0, fault_cnt_i};
      OFF_FIRST:  rdata = first_i;
      OFF_THRESH: rdata = {28'd0, thresh_q};
      default:    rdata = '0;
    endcase

    ack_d = access;
    dat_d = rd ? rdata : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= PERSIST_TH;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign en_o      = en_q;
  assign irq_en_o  = irq_en_q;
  assign thresh_o  = thresh_q;

endmodule

// File: rtl/alu_fault_monitor.sv
// alu_fault_monitor
//   Consumes the lockstep comparator's mismatch vector, counts samples and
//   faults, snapshots the first fault, classifies faults as transient or
//   persistent and raises a level interrupt. Register access via Wishbone.
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   cmp_valid, x, y        comparator sample strobe and mismatch bits
//   alu_out1, alu_out2     lane results, captured with the first fault
//   wbs_*                  Wishbone slave bus
//   fault_o                sticky fault flag
//   irq_o                  level interrupt (irq_en & (sticky | locked))
module alu_fault_monitor
  import alu_fault_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [3:0]  PERSIST_TH = 4'd3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmp_valid,
  input  logic [3:0]  x,
  input  logic        y,
  input  logic [3:0]  alu_out1,
  input  logic [3:0]  alu_out2,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        fault_o,
  output logic        irq_o
);

  logic        en, irq_en, clr, clr_en;
  logic [3:0]  thresh;

  logic [31:0] sample_cnt_q, sample_cnt_d;
  logic [15:0] fault_cnt_q, fault_cnt_d;
  logic [3:0]  cons_q, cons_d;
  logic        sticky_q, sticky_d;
  logic [31:0] first_q, first_d;
  fsm_state_e  state_q, state_d;

  logic        s, f;

  alu_fault_wb_regs #(
    .BASE_ADDR  (BASE_ADDR),
    .PERSIST_TH (PERSIST_TH)
  ) u_regs (
    .clk          (wb_clk_i),
    .srst         (wb_rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .sticky_i     (sticky_q),
    .state_i      (state_q),
    .cons_i       (cons_q),
    .sample_cnt_i (sample_cnt_q),
    .fault_cnt_i  (fault_cnt_q),
    .first_i      (first_q),
    .en_o         (en),
    .irq_en_o     (irq_en),
    .thresh_o     (thresh),
    .clr_o        (clr),
    .clr_en_o     (clr_en)
  );

  always_comb begin
    s = cmp_valid & en;
    f = s & ((|x) | y);

    sample_cnt_d = sample_cnt_q;
    fault_cnt_d  = fault_cnt_q;
    cons_d       = cons_q;
    sticky_d     = sticky_q;
    first_d      = first_q;
    state_d      = state_q;

    if (clr) begin
      // Clear has priority: any sample arriving in the same cycle is dropped.
      sample_cnt_d = '0;
      fault_cnt_d  = '0;
      cons_d       = '0;
      sticky_d     = 1'b0;
      first_d      = '0;
      state_d      = clr_en ? ST_MONITOR : ST_IDLE;
    end else begin
      if (s && (sample_cnt_q != '1)) sample_cnt_d = sample_cnt_q + 32'd1;

      if (f) begin
        if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 16'd1;
        if (cons_q != '1)      cons_d      = cons_q + 4'd1;
        sticky_d = 1'b1;
        // Index is the count of samples seen before this one.
        if (!sticky_q) first_d = pack_first(x, y, alu_out1, alu_out2, sample_cnt_q[15:0]);
      end else if (s) begin
        cons_d = '0;
      end

      // Threshold is compared against the run length including this sample.
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_MONITOR;
        end
        ST_MONITOR: begin
          if (!en)     state_d = ST_IDLE;
          else if (f)  state_d = (cons_d >= thresh) ? ST_LOCKED : ST_TRANSIENT;
        end
        ST_TRANSIENT: begin
          if (!en)                       state_d = ST_IDLE;
          else if (f && cons_d >= thresh) state_d = ST_LOCKED;
          else if (s && !f)              state_d = ST_MONITOR;
        end
        ST_LOCKED: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sample_cnt_q <= '0;
      fault_cnt_q  <= '0;
      cons_q       <= '0;
      sticky_q     <= 1'b0;
      first_q      <= '0;
      state_q      <= ST_IDLE;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
      cons_q       <= cons_d;
      sticky_q     <= sticky_d;
      first_q      <= first_d;
      state_q      <= state_d;
    end
  end

  assign fault_o = sticky_q;
  assign irq_o   = irq_en & (sticky_q | (state_q == ST_LOCKED));

endmodule

// File: tb/tb_alu_fault_monitor.sv
// tb_alu_fault_monitor
//   Directed bench: a table of Wishbone register accesses with expected
//   ack/data after reset, followed by hand-written sequences for sampling,
//   first-fault capture, lock-up, clear priority and counter saturation.
module tb_alu_fault_monitor;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmp_valid = 1'b0;
  logic [3:0]  x = '0;
  logic        y = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  a2 = '0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        fault_o, irq_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_fault_monitor #(.BASE_ADDR(BASE), .PERSIST_TH(4'd3)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmp_valid (cmp_valid),
    .x         (x),
    .y         (y),
    .alu_out1  (a1),
    .alu_out2  (a2),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .fault_o   (fault_o),
    .irq_o     (irq_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One Wishbone access; waits at most 4 cycles for ack.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic acked,
                         output logic [31:0] rd, output int lat);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    acked = 1'b0; rd = '0; lat = 0;
    for (int i = 1; i <= 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1; rd = dat_o; lat = i;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    logic acked; logic [31:0] rd; int lat;
    wb_xfer(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, acked, rd, lat);
    check({name, " ack"}, {31'd0, acked}, 32'd1);
    check(name, rd, exp);
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d);
    logic acked; logic [31:0] rd; int lat;
    wb_xfer(1'b1, BASE + {24'd0, off}, d, 4'hF, acked, rd, lat);
    check("write ack", {31'd0, acked}, 32'd1);
  endtask

  task automatic smp(input logic [3:0] xx, input logic yy, input logic [3:0] o1, input logic [3:0] o2);
    @(negedge clk);
    cmp_valid = 1'b1; x = xx; y = yy; a1 = o1; a2 = o2;
    @(posedge clk); #1;
    cmp_valid = 1'b0; x = '0; y = 1'b0;
  endtask

  initial begin
    logic acked; logic [31:0] rd; int lat;

    vecs[0]  = '{1'b0, BASE + 32'h00, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, BASE + 32'h08, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, BASE + 32'h0C, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, BASE + 32'h14, 32'h0, 4'hF, 1'b1, 32'h3};
    vecs[6]  = '{1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, BASE + 32'h100, 32'h0, 4'hF, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, BASE + 32'h14, 32'h5, 4'h0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, BASE + 32'h14, 32'h0, 4'hF, 1'b1, 32'h3};
    vecs[10] = '{1'b1, BASE + 32'h14, 32'h0, 4'h1, 1'b1, 32'h0};
    vecs[11] = '{1'b0, BASE + 32'h14, 32'h0, 4'hF, 1'b1, 32'h1};
    vecs[12] = '{1'b1, BASE + 32'h14, 32'h3, 4'hF, 1'b1, 32'h0};
    vecs[13] = '{1'b0, BASE + 32'h14, 32'h0, 4'hF, 1'b1, 32'h3};
    vecs[14] = '{1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[15] = '{1'b0, BASE + 32'h00, 32'h0, 4'hF, 1'b1, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    check("reset fault_o", {31'd0, fault_o}, 32'd0);
    check("reset irq_o", {31'd0, irq_o}, 32'd0);
    check("idle dat_o", dat_o, 32'd0);

    for (int i = 0; i < 16; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, acked, rd, lat);
      check($sformatf("vec%0d ack", i), {31'd0, acked}, {31'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d data", i), rd, vecs[i].exp_dat);
      if (vecs[i].exp_ack) check($sformatf("vec%0d latency", i), lat, 32'd1);
    end

    // Ten clean samples.
    wb_wr(8'h00, 32'h1);
    for (int i = 0; i < 10; i++) smp(4'h0, 1'b0, 4'h3, 4'h3);
    wb_rd(8'h08, 32'd10, "clean SAMPLE_CNT");
    wb_rd(8'h0C, 32'd0, "clean FAULT_CNT");
    wb_rd(8'h04, 32'h04, "clean STATUS");

    // First-fault capture on sample 5.
    wb_wr(8'h00, 32'h7);
    for (int i = 0; i < 4; i++) smp(4'h0, 1'b0, 4'h1, 4'h1);
    check("pre-fault fault_o", {31'd0, fault_o}, 32'd0);
    smp(4'b0010, 1'b0, 4'h6, 4'h4);
    check("fault_o next cycle", {31'd0, fault_o}, 32'd1);
    check("irq_o next cycle", {31'd0, irq_o}, 32'd1);
    wb_rd(8'h10, 32'h0004_4602, "FIRST");
    wb_rd(8'h04, 32'h19, "STATUS transient");
    smp(4'h0, 1'b0, 4'h2, 4'h2);
    wb_rd(8'h04, 32'h05, "STATUS back to monitor");
    smp(4'h8, 1'b0, 4'hF, 4'h7);
    wb_rd(8'h10, 32'h0004_4602, "FIRST unchanged");
    smp(4'h0, 1'b0, 4'h2, 4'h2);

    // Persistent fault with THRESH=2.
    wb_wr(8'h14, 32'h2);
    smp(4'h0, 1'b1, 4'h0, 4'h0);
    smp(4'h0, 1'b1, 4'h0, 4'h0);
    wb_rd(8'h04, 32'h2F, "STATUS locked");
    wb_wr(8'h00, 32'h2);
    wb_rd(8'h04, 32'h2F, "locked ignores en=0");
    check("irq_o locked", {31'd0, irq_o}, 32'd1);
    wb_wr(8'h00, 32'h5);
    wb_rd(8'h08, 32'd0, "cleared SAMPLE_CNT");
    wb_rd(8'h0C, 32'd0, "cleared FAULT_CNT");
    wb_rd(8'h04, 32'h04, "cleared STATUS");
    check("irq_o after clear", {31'd0, irq_o}, 32'd0);
    check("fault_o after clear", {31'd0, fault_o}, 32'd0);

    // Clear and fault in the same cycle: clear wins.
    smp(4'h1, 1'b0, 4'h0, 4'h0);
    wb_rd(8'h0C, 32'd1, "FAULT_CNT before clear");
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; dat_i = 32'h5; sel = 4'hF;
    cmp_valid = 1'b1; x = 4'h4;
    @(posedge clk); #1;
    cmp_valid = 1'b0; x = '0;
    check("clear+fault ack", {31'd0, ack}, 32'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    wb_rd(8'h0C, 32'd0, "clear wins FAULT_CNT");
    wb_rd(8'h04, 32'h04, "clear wins STATUS");

    // THRESH=1 locks on the first fault.
    wb_wr(8'h14, 32'h1);
    smp(4'h0, 1'b1, 4'h0, 4'h0);
    wb_rd(8'h04, 32'h1F, "THRESH=1 locks");
    wb_wr(8'h00, 32'h5);

    // Saturation of FAULT_CNT.
    @(negedge clk);
    force dut.fault_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.fault_cnt_q;
    smp(4'h1, 1'b0, 4'h0, 4'h0);
    wb_rd(8'h0C, 32'h0000_FFFF, "FAULT_CNT reaches max");
    smp(4'h1, 1'b0, 4'h0, 4'h0);
    wb_rd(8'h0C, 32'h0000_FFFF, "FAULT_CNT saturates");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
